// File: rtl/rect_fill.sv
// Rectangle fill engine: writes every pixel of a clipped rectangle to RAM port B in raster order.
// First write one cycle after start; a pixel is held on the port until rdy_b accepts it.
module rect_fill #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 200
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [8:0] i_x0,
   input  logic [7:0] i_y0,
   input  logic [8:0] i_x1,
   input  logic [7:0] i_y1,
   input  logic       i_color,
   input  logic       i_mode,
   output logic [8:0] o_x_b,
   output logic [7:0] o_y_b,
   output logic       o_write_b,
   output logic       o_in_b,
   input  logic       i_rdy_b,
   output logic       o_busy,
   output logic       o_done
);

   localparam logic [8:0] XMAX = 9'(WIDTH - 1);
   localparam logic [7:0] YMAX = 8'(HEIGHT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

   state_t     r_state;
   state_t     w_next;
   logic [8:0] r_x;
   logic [7:0] r_y;
   logic [8:0] r_x0;
   logic [8:0] r_xe;
   logic [7:0] r_ye;
   logic       r_color;
   logic       r_mode;

   logic [8:0] w_xe;
   logic [7:0] w_ye;
   logic       w_empty;
   logic       w_last;
   logic       w_row_end;

   // Clip the far corner to the framebuffer; near corner beyond the edge means nothing to draw.
   assign w_xe      = (i_x1 > XMAX) ? XMAX : i_x1;
   assign w_ye      = (i_y1 > YMAX) ? YMAX : i_y1;
   assign w_empty   = (i_x0 > w_xe) || (i_y0 > w_ye) || (i_x0 > XMAX) || (i_y0 > YMAX);
   assign w_row_end = (r_x == r_xe);
   assign w_last    = w_row_end && (r_y == r_ye);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = w_empty ? S_DONE : S_WRITE;
         S_WRITE: if (i_rdy_b && w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_x     <= '0;
         r_y     <= '0;
         r_x0    <= '0;
         r_xe    <= '0;
         r_ye    <= '0;
         r_color <= 1'b0;
         r_mode  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start && !w_empty) begin
                  r_x     <= i_x0;
                  r_y     <= i_y0;
                  r_x0    <= i_x0;
                  r_xe    <= w_xe;
                  r_ye    <= w_ye;
                  r_color <= i_color;
                  r_mode  <= i_mode;
               end
            end
            S_WRITE: begin
               if (i_rdy_b && !w_last) begin
                  if (w_row_end) begin
                     r_x <= r_x0;
                     r_y <= r_y + 8'd1;
                  end else begin
                     r_x <= r_x + 9'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      o_write_b = (r_state == S_WRITE);
      o_busy    = (r_state != S_IDLE);
      o_done    = (r_state == S_DONE);
      o_x_b     = r_x;
      o_y_b     = r_y;
      o_in_b    = o_write_b & (r_color ^ (r_mode & (r_x[0] ^ r_y[0])));
   end

endmodule
